// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues synchronous imem reads and
// presents instr / PC+4 to IF/ID, honouring stall, redirect, halt and bad targets.
module fetch_stage #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA          = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = {ADDRESS_WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     is_taken,
    input  logic [DATA-1:0]          new_addr,
    input  logic                     halt_i,
    output logic                     imem_en,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA-1:0]          imem_rdata,
    output logic                     if_valid,
    output logic [DATA-1:0]          if_instr,
    output logic [ADDRESS_WIDTH-1:0] if_pc_plus_4,
    output logic                     flush_id,
    output logic                     halted,
    output logic                     err,
    output logic [31:0]              fetch_count,
    output logic [15:0]              redirect_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);

    state_t                   state_r, state_s;
    logic [ADDRESS_WIDTH-1:0] pc_r, pc_s;
    logic                     pend_valid_r, pend_valid_s;
    logic [ADDRESS_WIDTH-1:0] pend_pc_r, pend_pc_s;
    logic                     hold_valid_r, hold_valid_s;
    logic [DATA-1:0]          hold_instr_r, hold_instr_s;
    logic [ADDRESS_WIDTH-1:0] hold_pc4_r, hold_pc4_s;
    logic                     if_valid_r, if_valid_s;
    logic [DATA-1:0]          if_instr_r, if_instr_s;
    logic [ADDRESS_WIDTH-1:0] if_pc4_r, if_pc4_s;
    logic                     halted_r, err_r;
    logic [31:0]              fetch_count_r, fetch_count_s;
    logic [15:0]              redirect_count_r, redirect_count_s;
    logic                     imem_en_s;
    logic                     flush_s;

    assign imem_en_s = (state_r == ST_RUN) && !stall_i && !is_taken;
    assign flush_s   = (state_r == ST_RUN) && is_taken;

    // Next-state, delivery and issue decisions for every register
    always_comb begin
        state_s          = state_r;
        pc_s             = pc_r;
        pend_valid_s     = pend_valid_r;
        pend_pc_s        = pend_pc_r;
        hold_valid_s     = hold_valid_r;
        hold_instr_s     = hold_instr_r;
        hold_pc4_s       = hold_pc4_r;
        if_valid_s       = if_valid_r;
        if_instr_s       = if_instr_r;
        if_pc4_s         = if_pc4_r;
        redirect_count_s = redirect_count_r;

        if (if_valid_r && !stall_i) begin
            fetch_count_s = fetch_count_r + 32'd1;
        end else begin
            fetch_count_s = fetch_count_r;
        end

        case (state_r)
            ST_RUN: begin
                if (is_taken) begin
                    // A HALT arriving alongside a redirect is wrong-path, so redirect wins
                    pend_valid_s = 1'b0;
                    hold_valid_s = 1'b0;
                    if_valid_s   = 1'b0;
                    if (new_addr[1:0] == 2'b00) begin
                        pc_s             = ADDRESS_WIDTH'(new_addr);
                        redirect_count_s = redirect_count_r + 16'd1;
                    end else begin
                        state_s = ST_ERROR;
                    end
                end else if (halt_i) begin
                    state_s      = ST_HALTED;
                    pend_valid_s = 1'b0;
                    hold_valid_s = 1'b0;
                    if_valid_s   = 1'b0;
                end else begin
                    if (stall_i) begin
                        if (pend_valid_r) begin
                            hold_valid_s = 1'b1;
                            hold_instr_s = imem_rdata;
                            hold_pc4_s   = pend_pc_r + PC_STEP;
                        end else begin
                            hold_valid_s = hold_valid_r;
                        end
                    end else if (hold_valid_r) begin
                        if_valid_s   = 1'b1;
                        if_instr_s   = hold_instr_r;
                        if_pc4_s     = hold_pc4_r;
                        hold_valid_s = 1'b0;
                    end else if (pend_valid_r) begin
                        if_valid_s = 1'b1;
                        if_instr_s = imem_rdata;
                        if_pc4_s   = pend_pc_r + PC_STEP;
                    end else begin
                        if_valid_s = 1'b0;
                    end

                    pend_valid_s = imem_en_s;
                    if (imem_en_s) begin
                        pend_pc_s = pc_r;
                        pc_s      = pc_r + PC_STEP;
                    end else begin
                        pend_pc_s = pend_pc_r;
                    end
                end
            end
            ST_HALTED, ST_ERROR: begin
                pend_valid_s = 1'b0;
                hold_valid_s = 1'b0;
                if_valid_s   = 1'b0;
            end
            default: begin
                state_s      = ST_ERROR;
                pend_valid_s = 1'b0;
                hold_valid_s = 1'b0;
                if_valid_s   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_RUN;
            pc_r             <= RESET_PC;
            pend_valid_r     <= 1'b0;
            pend_pc_r        <= {ADDRESS_WIDTH{1'b0}};
            hold_valid_r     <= 1'b0;
            hold_instr_r     <= {DATA{1'b0}};
            hold_pc4_r       <= {ADDRESS_WIDTH{1'b0}};
            if_valid_r       <= 1'b0;
            if_instr_r       <= {DATA{1'b0}};
            if_pc4_r         <= {ADDRESS_WIDTH{1'b0}};
            halted_r         <= 1'b0;
            err_r            <= 1'b0;
            fetch_count_r    <= 32'd0;
            redirect_count_r <= 16'd0;
        end else begin
            state_r          <= state_s;
            pc_r             <= pc_s;
            pend_valid_r     <= pend_valid_s;
            pend_pc_r        <= pend_pc_s;
            hold_valid_r     <= hold_valid_s;
            hold_instr_r     <= hold_instr_s;
            hold_pc4_r       <= hold_pc4_s;
            if_valid_r       <= if_valid_s;
            if_instr_r       <= if_instr_s;
            if_pc4_r         <= if_pc4_s;
            halted_r         <= (state_s == ST_HALTED);
            err_r            <= (state_s == ST_ERROR);
            fetch_count_r    <= fetch_count_s;
            redirect_count_r <= redirect_count_s;
        end
    end

    assign imem_en        = imem_en_s;
    assign imem_addr      = pc_r;
    assign flush_id       = flush_s;
    assign if_valid       = if_valid_r;
    assign if_instr       = if_instr_r;
    assign if_pc_plus_4   = if_pc4_r;
    assign halted         = halted_r;
    assign err            = err_r;
    assign fetch_count    = fetch_count_r;
    assign redirect_count = redirect_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory word i holds 0x1000+i, checks are
// taken 1 time unit after each rising edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        is_taken = 1'b0;
    logic [31:0] new_addr = 32'd0;
    logic        halt_i = 1'b0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus_4;
    logic        flush_id;
    logic        halted;
    logic        err;
    logic [31:0] fetch_count;
    logic [15:0] redirect_count;

    int tests = 0;
    int fails = 0;

    fetch_stage #(.ADDRESS_WIDTH(32), .DATA(32), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .is_taken(is_taken),
        .new_addr(new_addr), .halt_i(halt_i), .imem_en(imem_en),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc_plus_4(if_pc_plus_4), .flush_id(flush_id),
        .halted(halted), .err(err), .fetch_count(fetch_count),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word i = 0x1000 + i
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'h1000 + (imem_addr >> 2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p4);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
        chk({tag, ".instr"}, if_instr, ins);
        chk({tag, ".pc4"}, if_pc_plus_4, p4);
    endtask

    task automatic chk_reset(input string tag);
        chk_if(tag, 1'b0, 32'd0, 32'd0);
        chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
        chk({tag, ".err"}, {31'd0, err}, 32'd0);
        chk({tag, ".fcnt"}, fetch_count, 32'd0);
        chk({tag, ".rcnt"}, {16'd0, redirect_count}, 32'd0);
        chk({tag, ".addr"}, imem_addr, 32'd0);
    endtask

    initial begin
        // 1: reset and back-to-back fetch
        tick();
        chk_reset("rst1");
        rst = 1'b0;
        #1 chk("t1.en", {31'd0, imem_en}, 32'd1);
        tick(); chk("t1.e1.valid", {31'd0, if_valid}, 32'd0);
        tick(); chk_if("t1.e2", 1'b1, 32'h1000, 32'd4);
        tick(); chk_if("t1.e3", 1'b1, 32'h1001, 32'd8);
        tick(); chk_if("t1.e4", 1'b1, 32'h1002, 32'd12);
        tick(); chk_if("t1.e5", 1'b1, 32'h1003, 32'd16);
        chk("t1.fcnt", fetch_count, 32'd3);

        // 2: three-cycle stall with the 0x10 read in flight
        stall_i = 1'b1;
        #1 chk("t2.en", {31'd0, imem_en}, 32'd0);
        tick(); chk_if("t2.s1", 1'b1, 32'h1003, 32'd16);
        tick(); chk_if("t2.s2", 1'b1, 32'h1003, 32'd16);
        tick(); chk_if("t2.s3", 1'b1, 32'h1003, 32'd16);
        chk("t2.fcnt", fetch_count, 32'd3);
        stall_i = 1'b0;
        tick(); chk_if("t2.held", 1'b1, 32'h1004, 32'd20);
        tick(); chk_if("t2.next", 1'b1, 32'h1005, 32'd24);

        // 3: redirect to 0x40 while stalled
        is_taken = 1'b1; new_addr = 32'h40; stall_i = 1'b1;
        #1 chk("t3.flush", {31'd0, flush_id}, 32'd1);
        chk("t3.en", {31'd0, imem_en}, 32'd0);
        tick(); chk("t3.r1.valid", {31'd0, if_valid}, 32'd0);
        chk("t3.rcnt", {16'd0, redirect_count}, 32'd1);
        chk("t3.addr", imem_addr, 32'h40);
        is_taken = 1'b0; stall_i = 1'b0;
        tick(); chk("t3.r2.valid", {31'd0, if_valid}, 32'd0);
        tick(); chk_if("t3.tgt", 1'b1, 32'h1010, 32'h44);
        tick(); chk_if("t3.tgt2", 1'b1, 32'h1011, 32'h48);

        // 4b: halt together with redirect -> redirect wins
        is_taken = 1'b1; halt_i = 1'b1; new_addr = 32'h80;
        tick(); chk("t4b.halted", {31'd0, halted}, 32'd0);
        chk("t4b.rcnt", {16'd0, redirect_count}, 32'd2);
        chk("t4b.valid", {31'd0, if_valid}, 32'd0);
        is_taken = 1'b0; halt_i = 1'b0;
        tick();
        tick(); chk_if("t4b.tgt", 1'b1, 32'h1020, 32'h84);

        // 4a: halt alone, then a redirect must be ignored
        halt_i = 1'b1;
        tick(); chk("t4a.halted", {31'd0, halted}, 32'd1);
        chk("t4a.valid", {31'd0, if_valid}, 32'd0);
        halt_i = 1'b0; is_taken = 1'b1; new_addr = 32'h100;
        #1 chk("t4a.en", {31'd0, imem_en}, 32'd0);
        chk("t4a.flush", {31'd0, flush_id}, 32'd0);
        tick(); chk("t4a.rcnt", {16'd0, redirect_count}, 32'd2);
        is_taken = 1'b0;
        tick(); tick();
        chk("t4a.valid2", {31'd0, if_valid}, 32'd0);
        chk("t4a.halted2", {31'd0, halted}, 32'd1);
        chk("t4a.en2", {31'd0, imem_en}, 32'd0);

        // 5: misaligned redirect target
        rst = 1'b1;
        tick(); chk_reset("rst5");
        rst = 1'b0;
        tick(); tick(); chk_if("t5.first", 1'b1, 32'h1000, 32'd4);
        is_taken = 1'b1; new_addr = 32'h42;
        #1 chk("t5.flush", {31'd0, flush_id}, 32'd1);
        tick(); is_taken = 1'b0;
        chk("t5.err", {31'd0, err}, 32'd1);
        chk("t5.valid", {31'd0, if_valid}, 32'd0);
        chk("t5.rcnt", {16'd0, redirect_count}, 32'd0);
        chk("t5.halted", {31'd0, halted}, 32'd0);
        #1 chk("t5.en", {31'd0, imem_en}, 32'd0);

        // 6: reset pulsed during a stall with a held instruction
        rst = 1'b1;
        tick(); rst = 1'b0;
        tick(); tick(); chk_if("t6.first", 1'b1, 32'h1000, 32'd4);
        stall_i = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick(); chk_reset("rst6");
        rst = 1'b0; stall_i = 1'b0;
        tick(); chk("t6.r1.valid", {31'd0, if_valid}, 32'd0);
        tick(); chk_if("t6.restart", 1'b1, 32'h1000, 32'd4);
        tick(); chk_if("t6.next", 1'b1, 32'h1001, 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS-lite 5-stage pipeline.
- Holds the PC and drives a synchronous instruction memory.
- Delivers instr/PC+4 to the IF/ID boundary.
- Consumes the branch/jump resolution from Execute (is_taken, new_addr): redirects the PC, squashes wrong-path fetches, and handles stall, halt and misaligned-target error.

Parameters:
ADDRESS_WIDTH, 32, PC / instruction address width
DATA, 32, instruction and new_addr width
RESET_PC, 0, byte address fetched first after reset (word-aligned)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall_i  input  1  hazard stall from decode; freeze issue and IF outputs
is_taken  input  1  Execute: control transfer taken this cycle
new_addr  input  DATA  Execute: target byte address, valid when is_taken
halt_i  input  1  decode saw HALT opcode this cycle
imem_en  output  1  read enable to instruction memory
imem_addr  output  ADDRESS_WIDTH  byte address (= pc register)
imem_rdata  input  DATA  instruction, valid the cycle after imem_en
if_valid  output  1  IF/ID register holds a valid instruction
if_instr  output  DATA  fetched instruction
if_pc_plus_4  output  ADDRESS_WIDTH  fetch address + 4
flush_id  output  1  combinational: squash instruction currently in ID
halted  output  1  sticky, fetch stopped by HALT
err  output  1  sticky, misaligned redirect target
fetch_count  output  32  instructions delivered (if_valid && !stall_i), wraps
redirect_count  output  16  accepted redirects, wraps

Behaviour:
- Reset (rst=1 at edge) overrides everything, including mid-stall and in-flight reads:
  - State: pc=RESET_PC, state=RUN.
  - Pending read and hold buffer cleared.
  - if_valid=0, if_instr=0, if_pc_plus_4=0, halted=0, err=0, both counters=0.
- States:
  - RUN: normal fetch.
  - HALTED: halted=1; exit only by rst.
  - ERROR: err=1; exit only by rst.
  - In HALTED/ERROR: imem_en=0, if_valid=0, flush_id=0, is_taken/halt_i ignored.
- Issue:
  - imem_en = (state==RUN) && !stall_i && !is_taken.
  - On an issuing edge: pend_valid<=1, pend_pc<=pc, pc<=pc+4 (modulo 2^ADDRESS_WIDTH, wrap silent).
  - At most one read in flight.
- Delivery, in the cycle after issue (rdata valid):
  - If !stall_i: if_valid<=1, if_instr<=imem_rdata, if_pc_plus_4<=pend_pc+4.
  - If stall_i: capture into a 1-entry hold buffer (hold_valid=1). IF outputs keep their values for the whole stall.
  - After stall release, the next edge presents hold contents (hold has priority over fresh data). Issue resumes the same cycle.
- Latency:
  - First if_valid=1 at the 2nd rising edge after rst deasserts (instr at RESET_PC).
  - Back-to-back thereafter: one per cycle.
- Redirect (is_taken=1 in RUN):
  - flush_id=1 in that cycle.
  - If new_addr[1:0]==0: at the edge pc<=new_addr, pend_valid<=0, hold_valid<=0, if_valid<=0, redirect_count++.
  - Target instr appears with if_valid=1 two edges later (issue, then deliver).
  - Redirect overrides stall_i (stall ignored that cycle).
- is_taken and halt_i in the same cycle: the redirect wins and halt_i is ignored, because the HALT is wrong-path.
- halt_i alone, in RUN: at the edge state<=HALTED, if_valid<=0, pending/hold dropped.
- Misaligned redirect (is_taken && new_addr[1:0]!=0):
  - flush_id=1.
  - At the edge state<=ERROR, if_valid<=0. pc unchanged, redirect_count unchanged.
- fetch_count increments on each cycle with if_valid && !stall_i.

Test Plan:
1. Reset with RESET_PC=0; memory word i = 0x1000+i; no stall -> if_valid first at edge 2; if_instr 0x1000, 0x1001, 0x1002 with if_pc_plus_4 4, 8, 12 on consecutive cycles; fetch_count=3 after 3 deliveries.
2. Assert stall_i 3 cycles while a read is in flight -> IF outputs frozen, imem_en=0; after release, held instr delivered next edge then sequence continues with no loss or duplicate.
3. is_taken=1, new_addr=0x40 mid-stream (also with stall_i=1) -> flush_id=1 that cycle; if_valid=0 for 2 edges; then if_instr=mem[0x40>>2], if_pc_plus_4=0x44; redirect_count=1.
4. halt_i=1 alone -> halted=1, if_valid=0 and imem_en=0 forever; later is_taken ignored. Repeat with halt_i and is_taken both 1 -> no halt, redirect taken.
5. is_taken=1, new_addr=0x42 -> err=1, state ERROR, imem_en=0, redirect_count unchanged.
6. rst pulsed during stall with a hold entry and an in-flight read -> all outputs at reset values next cycle; fetch restarts at RESET_PC; the old held instruction is never delivered.
